// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C master among NUM_REQ requesters.
// Grant 1 clk after req; done/err 1 clk after busy falls or timeout; losers simply hold req.
module i2c_txn_arbiter #(
   parameter int DATA_WIDTH    = 8,
   parameter int NUM_REQ       = 4,
   parameter int START_TIMEOUT = 16,
   parameter int TXN_TIMEOUT   = 4096
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [NUM_REQ-1:0]                  req_wrEn,
   input  logic [NUM_REQ*(DATA_WIDTH-1)-1:0]   req_slvAddr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_regAddr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_dataIn,
   output logic [NUM_REQ-1:0]                  gnt,
   output logic [NUM_REQ-1:0]                  done,
   output logic [NUM_REQ-1:0]                  err,
   output logic                                mst_newTXN,
   output logic                                mst_wrEn,
   output logic [DATA_WIDTH-2:0]               mst_slvAddr,
   output logic [DATA_WIDTH-1:0]               mst_regAddr,
   output logic [DATA_WIDTH-1:0]               mst_dataIn,
   input  logic                                mst_busy
);

   localparam int PW    = $clog2(NUM_REQ);
   localparam int MAXTO = (TXN_TIMEOUT > START_TIMEOUT) ? TXN_TIMEOUT : START_TIMEOUT;
   localparam int CW    = $clog2(MAXTO) + 1;
   localparam int SW    = DATA_WIDTH - 1;

   localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
   localparam logic [CW-1:0] TXN_LAST   = CW'(TXN_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX    = '1;
   localparam logic [PW-1:0] PTR_LAST   = PW'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2,
      RELEASE   = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   g_idx;
   logic [PW-1:0]   pick_idx;
   logic            pick_vld;
   logic [CW-1:0]   cnt;
   logic            capture;
   logic            finish_ok;
   logic            finish_err;
   logic [PW:0]     scan_idx;

   // First requester at or after rr_ptr, wrapping at NUM_REQ-1.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      scan_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = {1'b0, rr_ptr} + (PW+1)'(i);
         if (scan_idx >= (PW+1)'(NUM_REQ)) begin
            scan_idx = scan_idx - (PW+1)'(NUM_REQ);
         end
         if (!pick_vld && req[scan_idx[PW-1:0]]) begin
            pick_vld = 1'b1;
            pick_idx = scan_idx[PW-1:0];
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      capture    = 1'b0;
      finish_ok  = 1'b0;
      finish_err = 1'b0;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               capture   = 1'b1;
               state_nxt = LAUNCH;
            end
         end
         LAUNCH: begin
            // Busy wins over the timeout when both land on the same cycle.
            if (mst_busy) begin
               state_nxt = WAIT_DONE;
            end else if (cnt == START_LAST) begin
               finish_err = 1'b1;
               state_nxt  = RELEASE;
            end
         end
         WAIT_DONE: begin
            if (!mst_busy) begin
               finish_ok = 1'b1;
               state_nxt = RELEASE;
            end else if (cnt == TXN_LAST) begin
               finish_err = 1'b1;
               state_nxt  = RELEASE;
            end
         end
         RELEASE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr      <= '0;
         g_idx       <= '0;
         cnt         <= '0;
         gnt         <= '0;
         done        <= '0;
         err         <= '0;
         mst_newTXN  <= 1'b0;
         mst_wrEn    <= 1'b0;
         mst_slvAddr <= '0;
         mst_regAddr <= '0;
         mst_dataIn  <= '0;
      end else begin
         done <= '0;
         err  <= '0;

         // Cleared on every state entry, saturating otherwise.
         if (state_nxt != state) begin
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end

         if (capture) begin
            g_idx       <= pick_idx;
            gnt         <= NUM_REQ'(1) << pick_idx;
            mst_newTXN  <= 1'b1;
            mst_wrEn    <= req_wrEn[pick_idx];
            mst_slvAddr <= req_slvAddr[int'(pick_idx)*SW +: SW];
            mst_regAddr <= req_regAddr[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            mst_dataIn  <= req_dataIn[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
         end

         if (state == LAUNCH && state_nxt != LAUNCH) begin
            mst_newTXN <= 1'b0;
         end

         // gnt is one-hot for the owner, so it doubles as the pulse mask.
         if (finish_ok) begin
            done <= gnt;
         end
         if (finish_err) begin
            err <= gnt;
         end

         if (state == RELEASE) begin
            gnt    <= '0;
            rr_ptr <= (g_idx == PTR_LAST) ? '0 : g_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Randomized bench for i2c_txn_arbiter against a transaction-level model.
module tb_i2c_txn_arbiter;

   localparam int DW       = 8;
   localparam int NREQ     = 4;
   localparam int START_TO = 16;
   localparam int TXN_TO   = 64;
   localparam int SAW      = NREQ*(DW-1);
   localparam int RAW      = NREQ*DW;

   typedef struct packed {
      logic [3:0]  gnt;
      logic [15:0] lat;
      logic        ntx;
      logic        wr;
      logic [6:0]  slv;
      logic [7:0]  rg;
      logic [7:0]  dat;
   } gobs_t;

   typedef struct packed {
      logic [15:0] ntx_cnt;
      logic [15:0] pulse_k;
      logic [3:0]  done;
      logic [3:0]  err;
      logic [3:0]  gnt_p;
      logic [3:0]  after;
      logic        stable;
   } cobs_t;

   logic            clk;
   logic            rst;
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] req_wrEn;
   logic [SAW-1:0]  req_slvAddr;
   logic [RAW-1:0]  req_regAddr;
   logic [RAW-1:0]  req_dataIn;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] done;
   logic [NREQ-1:0] err;
   logic            mst_newTXN;
   logic            mst_wrEn;
   logic [DW-2:0]   mst_slvAddr;
   logic [DW-1:0]   mst_regAddr;
   logic [DW-1:0]   mst_dataIn;
   logic            mst_busy;

   int checks;
   int errors;
   int ptr;

   i2c_txn_arbiter #(
      .DATA_WIDTH(DW), .NUM_REQ(NREQ), .START_TIMEOUT(START_TO), .TXN_TIMEOUT(TXN_TO)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_wrEn(req_wrEn),
      .req_slvAddr(req_slvAddr), .req_regAddr(req_regAddr), .req_dataIn(req_dataIn),
      .gnt(gnt), .done(done), .err(err), .mst_newTXN(mst_newTXN), .mst_wrEn(mst_wrEn),
      .mst_slvAddr(mst_slvAddr), .mst_regAddr(mst_regAddr), .mst_dataIn(mst_dataIn),
      .mst_busy(mst_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: round-robin choice from the pointer.
   function automatic int next_grant(input logic [3:0] r, input int p);
      for (int i = 0; i < NREQ; i++) begin
         int j;
         j = (p + i) % NREQ;
         if (((r >> j) & 4'd1) != 4'd0) return j;
      end
      return -1;
   endfunction

   function automatic gobs_t predict_grant(input int g);
      gobs_t e;
      e.gnt = 4'(1 << g);
      e.lat = 16'd1;
      e.ntx = 1'b1;
      e.wr  = req_wrEn[g];
      e.slv = req_slvAddr[g*(DW-1) +: DW-1];
      e.rg  = req_regAddr[g*DW +: DW];
      e.dat = req_dataIn[g*DW +: DW];
      return e;
   endfunction

   // Busy rises d cycles into the start request and lasts h cycles.
   function automatic cobs_t predict_done(input int d, input int h, input int g);
      cobs_t c;
      c = '0;
      c.stable = 1'b1;
      c.gnt_p  = 4'(1 << g);
      if (d >= START_TO) begin
         c.ntx_cnt = 16'(START_TO);
         c.pulse_k = 16'(START_TO);
         c.err     = c.gnt_p;
      end else begin
         c.ntx_cnt = 16'(d + 1);
         if (h > TXN_TO) begin
            c.pulse_k = 16'(d + TXN_TO + 1);
            c.err     = c.gnt_p;
         end else begin
            c.pulse_k = 16'(d + h + 1);
            c.done    = c.gnt_p;
         end
      end
      return c;
   endfunction

   // Starts at an IDLE negedge, ends at the IDLE negedge after release.
   task automatic drive_txn(input int d, input int h, input bit mutate,
                            output gobs_t go, output cobs_t co);
      int k;
      bit got;
      go = '0;
      co = '0;
      co.stable = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (gnt == '0 && k < 8);
      go.gnt = gnt;
      go.lat = 16'(k);
      go.ntx = mst_newTXN;
      go.wr  = mst_wrEn;
      go.slv = mst_slvAddr;
      go.rg  = mst_regAddr;
      go.dat = mst_dataIn;
      if (gnt == '0) return;
      got = 1'b0;
      k = 0;
      while (!got && k < 300) begin
         if (mst_newTXN) co.ntx_cnt = co.ntx_cnt + 16'd1;
         if (done != '0 || err != '0) begin
            got = 1'b1;
            co.pulse_k = 16'(k);
            co.done    = done;
            co.err     = err;
            co.gnt_p   = gnt;
         end else begin
            if (gnt !== go.gnt ||
                {mst_wrEn, mst_slvAddr, mst_regAddr, mst_dataIn} !== {go.wr, go.slv, go.rg, go.dat})
               co.stable = 1'b0;
            mst_busy = (d < START_TO && k >= d && k < d + h);
            if (mutate && k == 1) begin
               req_dataIn  = {NREQ{8'h3C}};
               req_regAddr = $urandom;
               req_slvAddr = SAW'($urandom);
               req_wrEn    = ~req_wrEn;
               req         = req & ~go.gnt;
            end
            @(negedge clk);
            k++;
         end
      end
      mst_busy = 1'b0;
      if (!got) begin
         co.pulse_k = 16'hFFFF;
         return;
      end
      @(negedge clk);
      co.after = done | err | gnt;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({gnt, done, err, mst_newTXN, mst_wrEn, mst_slvAddr, mst_regAddr, mst_dataIn} !== '0) begin
         errors++;
         $display("FAIL reset_state: got gnt=%b done=%b err=%b ntx=%b ops=%h/%h/%h, want all 0",
                  gnt, done, err, mst_newTXN, mst_slvAddr, mst_regAddr, mst_dataIn);
      end
      rst = 1'b0;
      ptr = 0;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      gobs_t go, eg;
      cobs_t co, ec;
      int g;
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         req_wrEn = 4'($urandom); req_slvAddr = SAW'($urandom);
         req_regAddr = $urandom;  req_dataIn = $urandom;
         g  = next_grant(req, ptr);
         eg = predict_grant(g);
         ec = predict_done(2, 6, g);
         drive_txn(2, 6, 1'b0, go, co);
         checks++;
         if (go !== eg) begin
            errors++;
            $display("FAIL rr_grant #%0d: got %p want %p", n, go, eg);
         end
         checks++;
         if (co !== ec) begin
            errors++;
            $display("FAIL rr_done #%0d: got %p want %p", n, co, ec);
         end
         ptr = (g + 1) % NREQ;
      end
      req = '0;
   endtask

   task automatic test_single_write(input bit mutate, input string tag);
      gobs_t go, eg;
      cobs_t co, ec;
      int g;
      req_wrEn = 4'b0001;
      req_slvAddr = SAW'($urandom);
      req_slvAddr[6:0] = 7'h50;
      req_regAddr = $urandom;
      req_regAddr[7:0] = 8'h10;
      req_dataIn = $urandom;
      req_dataIn[7:0] = 8'hA5;
      req = 4'b0001;
      g  = next_grant(req, ptr);
      eg = predict_grant(g);
      ec = predict_done(5, 40, g);
      drive_txn(5, 40, mutate, go, co);
      checks++;
      if (go !== eg) begin
         errors++;
         $display("FAIL %s grant: got %p want %p", tag, go, eg);
      end
      checks++;
      if (co !== ec) begin
         errors++;
         $display("FAIL %s done: got %p want %p", tag, co, ec);
      end
      ptr = (g + 1) % NREQ;
      req = '0;
   endtask

   task automatic test_timeouts();
      int dl[6] = '{99, 2, 15, 16, 3, 3};
      int hl[6] = '{0, 10, 8, 0, 64, 65};
      gobs_t go, eg;
      cobs_t co, ec;
      int g;
      req = 4'b0011;
      for (int n = 0; n < 6; n++) begin
         req_regAddr = $urandom;
         g  = next_grant(req, ptr);
         eg = predict_grant(g);
         ec = predict_done(dl[n], hl[n], g);
         drive_txn(dl[n], hl[n], 1'b0, go, co);
         checks++;
         if (go !== eg) begin
            errors++;
            $display("FAIL timeout_grant d=%0d h=%0d: got %p want %p", dl[n], hl[n], go, eg);
         end
         checks++;
         if (co !== ec) begin
            errors++;
            $display("FAIL timeout_done d=%0d h=%0d: got %p want %p", dl[n], hl[n], co, ec);
         end
         ptr = (g + 1) % NREQ;
      end
      req = '0;
   endtask

   task automatic test_reset_mid_txn();
      gobs_t go, eg;
      cobs_t co, ec;
      int g;
      logic [3:0] stray;
      req = 4'b0010;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0010) begin
         errors++;
         $display("FAIL midrst_grant: got %b want 0010", gnt);
      end
      mst_busy = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      checks++;
      if ({gnt, done, err, mst_newTXN, mst_wrEn, mst_slvAddr, mst_regAddr, mst_dataIn} !== '0) begin
         errors++;
         $display("FAIL midrst_clear: got gnt=%b done=%b err=%b ntx=%b ops=%h/%h/%h, want all 0",
                  gnt, done, err, mst_newTXN, mst_slvAddr, mst_regAddr, mst_dataIn);
      end
      rst = 1'b0;
      mst_busy = 1'b0;
      stray = '0;
      repeat (4) begin
         @(negedge clk);
         stray = stray | done | err;
      end
      checks++;
      if (stray !== 4'b0000) begin
         errors++;
         $display("FAIL midrst_no_pulse: got %b want 0000", stray);
      end
      ptr = 0;
      for (int n = 0; n < 2; n++) begin
         req = (n == 0) ? 4'b0101 : 4'b0100;
         g  = next_grant(req, ptr);
         eg = predict_grant(g);
         ec = predict_done(1, 3, g);
         drive_txn(1, 3, 1'b0, go, co);
         checks++;
         if (go !== eg) begin
            errors++;
            $display("FAIL midrst_regrant #%0d: got %p want %p", n, go, eg);
         end
         checks++;
         if (co !== ec) begin
            errors++;
            $display("FAIL midrst_redone #%0d: got %p want %p", n, co, ec);
         end
         ptr = (g + 1) % NREQ;
      end
      req = '0;
   endtask

   task automatic test_random();
      gobs_t go, eg;
      cobs_t co, ec;
      int g, d, h;
      bit mut;
      for (int n = 0; n < 25; n++) begin
         if ($urandom_range(0, 2) == 0 || req == '0) req = 4'($urandom_range(1, 15));
         req_wrEn = 4'($urandom); req_slvAddr = SAW'($urandom);
         req_regAddr = $urandom;  req_dataIn = $urandom;
         d   = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 20) : $urandom_range(0, 15);
         h   = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 20);
         mut = 1'($urandom_range(0, 1));
         g   = next_grant(req, ptr);
         eg  = predict_grant(g);
         ec  = predict_done(d, h, g);
         drive_txn(d, h, mut, go, co);
         checks++;
         if (go !== eg) begin
            errors++;
            $display("FAIL rand_grant #%0d d=%0d h=%0d: got %p want %p", n, d, h, go, eg);
         end
         checks++;
         if (co !== ec) begin
            errors++;
            $display("FAIL rand_done #%0d d=%0d h=%0d: got %p want %p", n, d, h, co, ec);
         end
         ptr = (g + 1) % NREQ;
      end
      req = '0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      ptr = 0;
      rst = 1'b1;
      req = '0;
      req_wrEn = '0;
      req_slvAddr = '0;
      req_regAddr = '0;
      req_dataIn = '0;
      mst_busy = 1'b0;
      test_reset();
      test_round_robin();
      test_single_write(1'b0, "single_write");
      test_single_write(1'b1, "operand_stability");
      test_timeouts();
      test_reset_mid_txn();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Round-robin arbiter and sequencer that shares the single I2C master among NUM_REQ requesters. It captures the winning requester's operands, launches one transaction with a held start request, tracks the master's busy flag to completion with timeouts, and returns a per-requester done or error pulse. It sits between the requesters and the master's newTXN/wrEn/slvAddr/regAddr/dataIn inputs, and runs on the system clock.

## Interface
- DATA_WIDTH, 8, data/register width; slave address is DATA_WIDTH-1 bits
- NUM_REQ, 4, number of requesters (2..8)
- START_TIMEOUT, 16, max clk cycles mst_newTXN is held waiting for mst_busy to rise
- TXN_TIMEOUT, 4096, max clk cycles mst_busy may stay high

Ports:
- clk  in  1  system clock; one clock, all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level
- req_wrEn  in  NUM_REQ  per-requester write enable
- req_slvAddr  in  NUM_REQ*(DATA_WIDTH-1)  packed slave addresses, requester i at slice i
- req_regAddr  in  NUM_REQ*DATA_WIDTH  packed register addresses
- req_dataIn  in  NUM_REQ*DATA_WIDTH  packed write data
- gnt  out  NUM_REQ  one-hot grant; high from capture through release
- done  out  NUM_REQ  one-cycle pulse: transaction completed
- err  out  NUM_REQ  one-cycle pulse: start or transaction timeout
- mst_newTXN  out  1  start request to master
- mst_wrEn, mst_slvAddr, mst_regAddr, mst_dataIn  out  1/DATA_WIDTH-1/DATA_WIDTH/DATA_WIDTH  registered operands to master
- mst_busy  in  1  master busy, already synchronous to clk

## Operation
- States: IDLE, LAUNCH, WAIT_DONE, RELEASE.
- IDLE: when any req is high, pick the first set bit at or after rr_ptr, wrapping from NUM_REQ-1 to 0. Latch that requester's operands into the mst_* registers, set its gnt bit, set mst_newTXN, and go to LAUNCH.
- LAUNCH: hold mst_newTXN high, because the master runs on a slower derived clock.
  - If mst_busy is seen high: drop mst_newTXN and go to WAIT_DONE.
  - If START_TIMEOUT cycles pass first: drop mst_newTXN, mark error, go to RELEASE.
- WAIT_DONE: when mst_busy goes low, go to RELEASE with success. If mst_busy stays high for TXN_TIMEOUT cycles, mark error and go to RELEASE.
- RELEASE: pulse done[g] or err[g] for exactly one cycle, clear gnt, set rr_ptr=(g+1) mod NUM_REQ, and go to IDLE.
- Operands are held stable on the mst_* outputs from capture until the next capture. Requester inputs are ignored outside the capture cycle.
- Withdrawing req after grant does not abort the transaction. It still completes and done or err still pulses.
- Withdrawing req before grant means that requester is not served.
- A requester wanting back-to-back transactions keeps req high. It is re-eligible in the IDLE cycle after its own RELEASE, but behind any other pending requesters.
- Only one transaction is in flight at a time. gnt is never multi-hot.

## Timing
- Reset values: state=IDLE, rr_ptr=0, gnt=0, done=0, err=0, mst_newTXN=0, mst_wrEn=0, all mst address/data=0, all counters=0.
- Reset mid-transaction: everything returns to reset values on the next edge. No done or err is issued for the aborted transaction.
- Grant latency: req sampled high in IDLE at edge N; gnt and mst_newTXN are high after edge N.
- mst_newTXN falls on the edge after mst_busy is sampled high. A start timeout fires after exactly START_TIMEOUT cycles in LAUNCH.
- done or err is asserted one cycle after mst_busy is sampled low, or one cycle after the timeout, for one cycle. gnt falls on the same edge that done or err falls.
- Minimum spacing between grants: one IDLE cycle.
- Counters are wide enough for their timeout value (clog2+1 bits), clear on every state entry, and never wrap.

## Test plan
- Single write: req[0]=1, slvAddr=7'h50, regAddr=8'h10, data=8'hA5, wrEn=1; BFM raises busy 5 cycles after newTXN and holds it 40 cycles -> mst_* equal these values, newTXN drops the cycle after busy rises, done[0] pulses once, gnt returns to 0.
- Round-robin: req=4'b1111 held -> grant order 0,1,2,3,0; rr_ptr wraps; no request starved; gnt always one-hot.
- Start timeout: BFM never raises busy -> newTXN high for exactly 16 cycles, err[g] pulses, done stays 0, next requester is granted.
- Transaction timeout with TXN_TIMEOUT=64: busy stuck high -> err pulses after 64 cycles in WAIT_DONE.
- Operand stability: change req_dataIn[0] to 8'h3C after grant -> mst_dataIn stays 8'hA5 for the whole transaction. Drop req[0] mid-transaction -> done[0] still pulses.
- Reset in WAIT_DONE -> all outputs return to 0 on the next edge, no done or err, rr_ptr=0, and a fresh req[2] is granted normally.
